// File: rtl/dcache_sa_wt.sv
// dcache_sa_wt: N-way set-associative, write-through, no-write-allocate,
// blocking data cache between the pipeline MEM stage and the memory arbiter.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   pipeline_dcache_*              request side (valid/ready handshake,
//                                  we, uc, addr, wdata, wstrb)
//   dcache_pipeline_rvalid/dout    one-cycle completion pulse and load data
//   dcache_mem_*/addrout_dcache/   memory request (req held until addrOK)
//   dout_dcache_mem
//   din_mem_dcache, mem_dcache_*   memory response (addrOK, dataOK, data)
//
// Lines are refilled word by word (one memory transaction per word). The
// victim is the lowest-numbered invalid way, otherwise the set's round-robin
// pointer. Uncached accesses bypass the arrays completely.
module dcache_sa_wt #(
  parameter int index_width  = 4,
  parameter int offset_width = 2,
  parameter int ways         = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pipeline_dcache_valid,
  output logic        dcache_pipeline_ready,
  input  logic        pipeline_dcache_we,
  input  logic        pipeline_dcache_uc,
  input  logic [31:0] pipeline_dcache_addr,
  input  logic [31:0] pipeline_dcache_wdata,
  input  logic [3:0]  pipeline_dcache_wstrb,
  output logic        dcache_pipeline_rvalid,
  output logic [31:0] dcache_pipeline_dout,
  output logic        dcache_mem_req,
  output logic        dcache_mem_wr,
  output logic [1:0]  dcache_mem_size,
  output logic [3:0]  dcache_mem_wstrb,
  output logic [31:0] addrout_dcache,
  output logic [31:0] dout_dcache_mem,
  input  logic [31:0] din_mem_dcache,
  input  logic        mem_dcache_addrOK,
  input  logic        mem_dcache_dataOK
);

  localparam int SETS  = 1 << index_width;
  localparam int WORDS = 1 << offset_width;
  localparam int TAG_W = 30 - index_width - offset_width;
  localparam int WW    = (ways > 1) ? $clog2(ways) : 1;
  localparam logic [WW-1:0] LAST_WAY = WW'(ways - 1);
  localparam logic [offset_width-1:0] LAST_WORD = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_WR_WAIT = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [29:0]             addr_q, addr_d;   // word address (byte bits dropped)
  logic                    we_q, we_d;
  logic                    uc_q, uc_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [WW-1:0]           way_q, way_d;     // way being refilled
  logic [offset_width-1:0] cnt_q, cnt_d;     // refill word counter

  logic              valid_q [ways][SETS];
  logic              valid_d [ways][SETS];
  logic [TAG_W-1:0]  tag_q   [ways][SETS];
  logic [TAG_W-1:0]  tag_d   [ways][SETS];
  logic [31:0]       data_q  [ways][SETS][WORDS];
  logic [31:0]       data_d  [ways][SETS][WORDS];
  logic [WW-1:0]     ptr_q   [SETS];
  logic [WW-1:0]     ptr_d   [SETS];

  logic [TAG_W-1:0]        tag_f;
  logic [index_width-1:0]  idx_f;
  logic [offset_width-1:0] off_f;
  logic                    hit, inv_found, accept;
  logic [WW-1:0]           hit_way, inv_way, victim;
  logic                    unused_addr_bits;

  assign tag_f = addr_q[29 -: TAG_W];
  assign idx_f = addr_q[offset_width +: index_width];
  assign off_f = addr_q[0 +: offset_width];

  // Requests are word aligned; the byte offset is deliberately discarded.
  assign unused_addr_bits = ^pipeline_dcache_addr[1:0];

  // Parallel tag compare over all ways; the descending loop leaves the
  // lowest-numbered invalid way in inv_way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (valid_q[w][idx_f] && (tag_q[w][idx_f] == tag_f)) begin
        hit     = 1'b1;
        hit_way = w[WW-1:0];
      end
      if (!valid_q[w][idx_f]) begin
        inv_found = 1'b1;
        inv_way   = w[WW-1:0];
      end
    end
  end

  assign victim = inv_found ? inv_way : ptr_q[idx_f];

  // A cached load hit completes in LOOKUP, so a new request can be taken in
  // the same cycle to sustain one hit per cycle.
  assign dcache_pipeline_ready = (state_q == S_IDLE) ||
                                 ((state_q == S_LOOKUP) && !we_q && !uc_q && hit);
  assign accept = pipeline_dcache_valid && dcache_pipeline_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    uc_d    = uc_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    dcache_pipeline_rvalid = 1'b0;
    dcache_pipeline_dout   = '0;

    // Capture only touches the _d copies, so the request still held in
    // LOOKUP is answered from the _q values this cycle.
    if (accept) begin
      addr_d  = pipeline_dcache_addr[31:2];
      we_d    = pipeline_dcache_we;
      uc_d    = pipeline_dcache_uc;
      wdata_d = pipeline_dcache_wdata;
      wstrb_d = pipeline_dcache_wstrb;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (uc_q) begin
          state_d = we_q ? S_WR_REQ : S_RD_REQ;
        end else if (we_q) begin
          // Write-through: keep the cached copy coherent, never allocate.
          if (hit) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) data_d[hit_way][idx_f][off_f][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
          state_d = S_WR_REQ;
        end else if (hit) begin
          dcache_pipeline_rvalid = 1'b1;
          dcache_pipeline_dout   = data_q[hit_way][idx_f][off_f];
          state_d = accept ? S_LOOKUP : S_IDLE;
        end else begin
          way_d   = victim;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem_dcache_addrOK) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_dcache_dataOK) begin
          if (uc_q) begin
            dcache_pipeline_rvalid = 1'b1;
            dcache_pipeline_dout   = din_mem_dcache;
            state_d = S_IDLE;
          end else begin
            data_d[way_q][idx_f][cnt_q] = din_mem_dcache;
            if (cnt_q == LAST_WORD) begin
              tag_d[way_q][idx_f]   = tag_f;
              valid_d[way_q][idx_f] = 1'b1;
              ptr_d[idx_f] = (ptr_q[idx_f] == LAST_WAY) ? '0 : ptr_q[idx_f] + WW'(1);
              state_d = S_RESP;
            end else begin
              cnt_d   = cnt_q + offset_width'(1);
              state_d = S_RD_REQ;
            end
          end
        end
      end
      S_RESP: begin
        dcache_pipeline_rvalid = 1'b1;
        dcache_pipeline_dout   = data_q[way_q][idx_f][off_f];
        state_d = S_IDLE;
      end
      S_WR_REQ: begin
        if (mem_dcache_addrOK) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_dcache_dataOK) begin
          dcache_pipeline_rvalid = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state, so they are
  // stable from req rise until addrOK and drop the cycle after it.
  assign dcache_mem_req   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign dcache_mem_wr    = (state_q == S_WR_REQ);
  assign dcache_mem_size  = 2'd2;
  assign dcache_mem_wstrb = (state_q == S_WR_REQ) ? wstrb_q : 4'h0;
  assign dout_dcache_mem  = (state_q == S_WR_REQ) ? wdata_q : 32'h0;

  always_comb begin
    addrout_dcache = '0;
    if (state_q == S_RD_REQ) begin
      addrout_dcache = uc_q ? {addr_q, 2'b00}
                            : {addr_q[29:offset_width], cnt_q, 2'b00};
    end else if (state_q == S_WR_REQ) begin
      addrout_dcache = {addr_q, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      uc_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '{default: 1'b0};
      ptr_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      uc_q    <= uc_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Tag and data contents are qualified by valid bits and need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_sa_wt.sv
// tb_dcache_sa_wt: self-checking bench for dcache_sa_wt (default parameters).
// A behavioural memory answers the cache bus with random latencies; a
// reference model (flat memory image plus per-set resident-tag lists)
// predicts load data, transaction counts and hit latency.
`timescale 1ns/1ps
module tb_dcache_sa_wt;

  localparam int IW    = 4;
  localparam int OW    = 2;
  localparam int WAYS  = 2;
  localparam int WORDS = 1 << OW;
  localparam int SETS  = 1 << IW;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pipeline_dcache_valid;
  logic        dcache_pipeline_ready;
  logic        pipeline_dcache_we;
  logic        pipeline_dcache_uc;
  logic [31:0] pipeline_dcache_addr;
  logic [31:0] pipeline_dcache_wdata;
  logic [3:0]  pipeline_dcache_wstrb;
  logic        dcache_pipeline_rvalid;
  logic [31:0] dcache_pipeline_dout;
  logic        dcache_mem_req;
  logic        dcache_mem_wr;
  logic [1:0]  dcache_mem_size;
  logic [3:0]  dcache_mem_wstrb;
  logic [31:0] addrout_dcache;
  logic [31:0] dout_dcache_mem;
  logic [31:0] din_mem_dcache;
  logic        mem_dcache_addrOK;
  logic        mem_dcache_dataOK;

  always #5 clk = ~clk;

  dcache_sa_wt #(.index_width(IW), .offset_width(OW), .ways(WAYS)) dut (
    .clk(clk), .rstn(rstn),
    .pipeline_dcache_valid(pipeline_dcache_valid),
    .dcache_pipeline_ready(dcache_pipeline_ready),
    .pipeline_dcache_we(pipeline_dcache_we),
    .pipeline_dcache_uc(pipeline_dcache_uc),
    .pipeline_dcache_addr(pipeline_dcache_addr),
    .pipeline_dcache_wdata(pipeline_dcache_wdata),
    .pipeline_dcache_wstrb(pipeline_dcache_wstrb),
    .dcache_pipeline_rvalid(dcache_pipeline_rvalid),
    .dcache_pipeline_dout(dcache_pipeline_dout),
    .dcache_mem_req(dcache_mem_req),
    .dcache_mem_wr(dcache_mem_wr),
    .dcache_mem_size(dcache_mem_size),
    .dcache_mem_wstrb(dcache_mem_wstrb),
    .addrout_dcache(addrout_dcache),
    .dout_dcache_mem(dout_dcache_mem),
    .din_mem_dcache(din_mem_dcache),
    .mem_dcache_addrOK(mem_dcache_addrOK),
    .mem_dcache_dataOK(mem_dcache_dataOK)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    string       name;
    logic        we;
    logic        uc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_dout;
    int          exp_ntx;
    bit          exp_hit;
  } vec_t;

  tx_t         txlog[$];
  vec_t        vecs[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          force_delay = -1;
  int          checks = 0;
  int          failures = 0;

  // Reference cache state: which line tags sit in which way of each set.
  int unsigned ref_tag   [SETS][WAYS];
  bit          ref_valid [SETS][WAYS];
  int          ref_ptr   [SETS];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural memory: addrOK after 0..2 cycles of req, dataOK 1..3 cycles
  // after addrOK (or a forced long delay); writes land when accepted.
  initial begin : responder
    logic        pend;
    int          a_wait;
    int          d_wait;
    logic [31:0] cur_addr;
    tx_t         t;
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;
    din_mem_dcache    = '0;
    pend     = 1'b0;
    a_wait   = 0;
    d_wait   = 0;
    cur_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_dcache_addrOK = 1'b0;
      mem_dcache_dataOK = 1'b0;
      din_mem_dcache    = $urandom;
      if (!rstn) begin
        pend   = 1'b0;
        a_wait = 0;
      end else if (pend) begin
        if (d_wait == 0) begin
          mem_dcache_dataOK = 1'b1;
          din_mem_dcache    = mem_rd(cur_addr);
          pend = 1'b0;
        end else begin
          d_wait--;
        end
      end else if (dcache_mem_req) begin
        if (a_wait == 0) begin
          mem_dcache_addrOK = 1'b1;
          cur_addr = {addrout_dcache[31:2], 2'b00};
          t.addr  = addrout_dcache;
          t.wr    = dcache_mem_wr;
          t.wstrb = dcache_mem_wstrb;
          t.wdata = dout_dcache_mem;
          txlog.push_back(t);
          if (dcache_mem_wr) mem[cur_addr] = merge(mem_rd(cur_addr), dout_dcache_mem, dcache_mem_wstrb);
          pend   = 1'b1;
          d_wait = (force_delay >= 0) ? force_delay : $urandom_range(0, 2);
          a_wait = $urandom_range(0, 2);
        end else begin
          a_wait--;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      ref_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        ref_valid[s][w] = 1'b0;
        ref_tag[s][w]   = 0;
      end
    end
  endtask

  // Predicts one access from the cache rules and updates the model.
  task automatic model_step(input logic we, input logic uc, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] exp_dout, output int exp_ntx,
                            output bit exp_hit);
    int unsigned line;
    int          s;
    int unsigned ltag;
    int          v;
    logic [31:0] wa;
    line = addr / (4 * WORDS);
    s    = int'(line % SETS);
    ltag = line / SETS;
    wa   = {addr[31:2], 2'b00};
    exp_hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (ref_valid[s][w] && ref_tag[s][w] == ltag) exp_hit = 1'b1;
    exp_dout = ref_rd(wa);
    if (we) begin
      exp_ntx = 1;
      ref_mem[wa] = merge(ref_rd(wa), wdata, wstrb);
      exp_dout = '0;
    end else if (uc) begin
      exp_ntx = 1;
      exp_hit = 1'b0;
    end else if (exp_hit) begin
      exp_ntx = 0;
    end else begin
      exp_ntx = WORDS;
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!ref_valid[s][w] && v < 0) v = w;
      if (v < 0) v = ref_ptr[s];
      ref_valid[s][v] = 1'b1;
      ref_tag[s][v]   = ltag;
      ref_ptr[s]      = (ref_ptr[s] + 1) % WAYS;
    end
  endtask

  // Issues one request (entered and left just after a rising edge) and
  // waits for its rvalid pulse; lat counts cycles from accept to rvalid.
  task automatic applyStimulus(input logic we, input logic uc, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               output logic [31:0] dout, output int lat,
                               output int ntx, output int first_tx);
    bit ok;
    first_tx = txlog.size();
    pipeline_dcache_valid = 1'b1;
    pipeline_dcache_we    = we;
    pipeline_dcache_uc    = uc;
    pipeline_dcache_addr  = addr;
    pipeline_dcache_wdata = wdata;
    pipeline_dcache_wstrb = wstrb;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (dcache_pipeline_ready) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      failures++;
      $display("[TB] FAIL ready_timeout: got 0 ready for addr 0x%08h, expected 1", addr);
    end
    @(posedge clk);
    #1;
    pipeline_dcache_valid = 1'b0;
    lat  = 0;
    dout = '0;
    ok   = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      lat++;
      if (dcache_pipeline_rvalid) begin dout = dcache_pipeline_dout; ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rvalid_timeout: got no rvalid for addr 0x%08h, expected a pulse", addr);
    end
    @(posedge clk);
    #1;
    ntx = txlog.size() - first_tx;
  endtask

  task automatic run_and_check(input string name, input logic we, input logic uc,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] exp_dout,
                               input int exp_ntx, input bit exp_hit);
    logic [31:0] dout;
    logic [31:0] base;
    int          lat;
    int          ntx;
    int          first;
    applyStimulus(we, uc, addr, wdata, wstrb, dout, lat, ntx, first);
    checkOutput({name, "_ntx"}, ntx, exp_ntx);
    if (!we) checkOutput({name, "_dout"}, dout, exp_dout);
    if (!we && !uc && exp_hit) checkOutput({name, "_hitlat"}, lat, 1);
    if (we && ntx == 1) begin
      checkOutput({name, "_wr"}, txlog[first].wr, 1);
      checkOutput({name, "_waddr"}, txlog[first].addr, {addr[31:2], 2'b00});
      checkOutput({name, "_wstrb"}, txlog[first].wstrb, wstrb);
      checkOutput({name, "_wdata"}, txlog[first].wdata, wdata);
    end
    if (!we && ntx == exp_ntx) begin
      base = (addr / (4 * WORDS)) * (4 * WORDS);
      for (int i = 0; i < ntx; i++) begin
        checkOutput({name, "_raddr"}, txlog[first + i].addr,
                    uc ? {addr[31:2], 2'b00} : base + 32'(4 * i));
        checkOutput({name, "_rd"}, txlog[first + i].wr, 0);
      end
    end
  endtask

  task automatic add_vec(input string name, input logic we, input logic uc,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_dout,
                         input int exp_ntx, input bit exp_hit);
    vec_t v;
    v.name = name; v.we = we; v.uc = uc; v.addr = addr; v.wdata = wdata;
    v.wstrb = wstrb; v.exp_dout = exp_dout; v.exp_ntx = exp_ntx; v.exp_hit = exp_hit;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] m_dout;
    int          m_ntx;
    bit          m_hit;
    logic [31:0] b2b_exp [4];
    int          tx0;
    bit          ok;
    logic        r_we;
    logic        r_uc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    int          r;

    rstn = 1'b0;
    pipeline_dcache_valid = 1'b0;
    pipeline_dcache_we    = 1'b0;
    pipeline_dcache_uc    = 1'b0;
    pipeline_dcache_addr  = '0;
    pipeline_dcache_wdata = '0;
    pipeline_dcache_wstrb = '0;
    model_reset();
    mem[32'h40] = 32'h11;     ref_mem[32'h40] = 32'h11;
    mem[32'h44] = 32'h22;     ref_mem[32'h44] = 32'h22;
    mem[32'h48] = 32'h33;     ref_mem[32'h48] = 32'h33;
    mem[32'h4C] = 32'h44;     ref_mem[32'h4C] = 32'h44;

    // Reset state of every output.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready",  dcache_pipeline_ready, 1);
    checkOutput("rst_rvalid", dcache_pipeline_rvalid, 0);
    checkOutput("rst_dout",   dcache_pipeline_dout, 0);
    checkOutput("rst_req",    dcache_mem_req, 0);
    checkOutput("rst_wr",     dcache_mem_wr, 0);
    checkOutput("rst_size",   dcache_mem_size, 2);
    checkOutput("rst_wstrb",  dcache_mem_wstrb, 0);
    checkOutput("rst_addr",   addrout_dcache, 0);
    checkOutput("rst_wdata",  dout_dcache_mem, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived expectations.
    add_vec("cold_ld40",   0, 0, 32'h40,   0, 4'h0, 32'h11,               4, 0);
    add_vec("hit_ld48",    0, 0, 32'h48,   0, 4'h0, 32'h33,               0, 1);
    add_vec("st_hit44",    1, 0, 32'h44,   32'hAABBCCDD, 4'b0011, 0,      1, 1);
    add_vec("ld44_merged", 0, 0, 32'h44,   0, 4'h0, 32'h0000CCDD,         0, 1);
    add_vec("st_miss1000", 1, 0, 32'h1000, 32'h12345678, 4'hF, 0,         1, 0);
    add_vec("ld1000_fill", 0, 0, 32'h1000, 0, 4'h0, 32'h12345678,         4, 0);
    add_vec("ld2000_B",    0, 0, 32'h2000, 0, 4'h0, init_word(32'h2000),  4, 0);
    add_vec("ld3000_C",    0, 0, 32'h3000, 0, 4'h0, init_word(32'h3000),  4, 0);
    add_vec("ld2004_Bhit", 0, 0, 32'h2004, 0, 4'h0, init_word(32'h2004),  0, 1);
    add_vec("ld1004_Amis", 0, 0, 32'h1004, 0, 4'h0, init_word(32'h1004),  4, 0);
    add_vec("uc_ld80_a",   0, 1, 32'h80,   0, 4'h0, init_word(32'h80),    1, 0);
    add_vec("uc_ld80_b",   0, 1, 32'h80,   0, 4'h0, init_word(32'h80),    1, 0);
    add_vec("ld80_cached", 0, 0, 32'h80,   0, 4'h0, init_word(32'h80),    4, 0);
    foreach (vecs[i]) begin
      model_step(vecs[i].we, vecs[i].uc, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                 m_dout, m_ntx, m_hit);
      run_and_check(vecs[i].name, vecs[i].we, vecs[i].uc, vecs[i].addr, vecs[i].wdata,
                    vecs[i].wstrb, vecs[i].exp_dout, vecs[i].exp_ntx, vecs[i].exp_hit);
    end

    // Four back-to-back hits on line 0x40: one rvalid per cycle.
    b2b_exp[0] = 32'h11; b2b_exp[1] = 32'h0000CCDD; b2b_exp[2] = 32'h33; b2b_exp[3] = 32'h44;
    tx0 = txlog.size();
    pipeline_dcache_valid = 1'b1;
    pipeline_dcache_we    = 1'b0;
    pipeline_dcache_uc    = 1'b0;
    pipeline_dcache_addr  = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) pipeline_dcache_addr = 32'h40 + 32'(4 * (i + 1));
      else pipeline_dcache_valid = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("b2b_rvalid%0d", i), dcache_pipeline_rvalid, 1);
      checkOutput($sformatf("b2b_dout%0d", i), dcache_pipeline_dout, b2b_exp[i]);
    end
    @(posedge clk);
    #1;
    checkOutput("b2b_ntx", txlog.size() - tx0, 0);

    // Reset while an uncached read waits for data.
    force_delay = 30;
    tx0 = txlog.size();
    pipeline_dcache_valid = 1'b1;
    pipeline_dcache_uc    = 1'b1;
    pipeline_dcache_addr  = 32'h80;
    @(posedge clk);
    #1;
    pipeline_dcache_valid = 1'b0;
    pipeline_dcache_uc    = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (txlog.size() > tx0) begin ok = 1'b1; break; end
    end
    checkOutput("abort_addrok_seen", ok, 1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("abort_req",    dcache_mem_req, 0);
    checkOutput("abort_ready",  dcache_pipeline_ready, 1);
    checkOutput("abort_rvalid", dcache_pipeline_rvalid, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    force_delay = -1;
    model_reset();
    @(posedge clk);
    #1;
    model_step(0, 0, 32'h40, 0, 4'h0, m_dout, m_ntx, m_hit);
    run_and_check("post_rst_ld40", 0, 0, 32'h40, 0, 4'h0, 32'h11, 4, 0);

    // Randomised traffic over a few conflicting sets, checked against the model.
    for (int n = 0; n < 200; n++) begin
      r       = $urandom_range(0, 15);
      r_uc    = (r < 2);
      r_we    = (r >= 11);
      r_addr  = (32'($urandom_range(1, 4)) << (IW + OW + 2)) |
                (32'($urandom_range(0, 2)) << (OW + 2)) |
                (32'($urandom_range(0, WORDS - 1)) << 2) |
                32'($urandom_range(0, 3));
      r_wdata = $urandom;
      r_strb  = 4'($urandom_range(0, 15));
      model_step(r_we, r_uc, r_addr, r_wdata, r_strb, m_dout, m_ntx, m_hit);
      run_and_check($sformatf("rnd%0d", n), r_we, r_uc, r_addr, r_wdata, r_strb,
                    m_dout, m_ntx, m_hit);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
